// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment content controller:
// FSM states, segment patterns, BCD sizing and the digit-to-segment table.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_ENC
  } state_e;

  localparam int unsigned BIN_W    = 20;
  localparam int unsigned BCD_W    = 24;
  localparam int unsigned NDIG     = 6;
  localparam int unsigned BCD_ITER = 20;

  localparam logic [BIN_W-1:0] BCD_MAX   = 20'd999999;
  localparam logic [7:0]       SEG_BLANK = 8'hff;
  localparam logic [7:0]       SEG_DASH  = 8'hbf;

  // Active-low segments, bit7 = decimal point (left off here).
  function automatic logic [7:0] digit_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hc0;
      4'd1:    s = 8'hf9;
      4'd2:    s = 8'ha4;
      4'd3:    s = 8'hb0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hf8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 20-bit binary to 6-digit BCD converter (double dabble),
// one iteration per clock; flags inputs that do not fit in six digits.
module bin2bcd_seq
  import seg_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output logic             ovf_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam logic [4:0] LAST_IT = 5'(BCD_ITER - 1);

  logic [BIN_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [4:0]       cnt_q;
  logic             busy_q, ovf_q;

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_d = {adj[BCD_W-2:0], sh_q[BIN_W-1]};
    sh_d  = {sh_q[BIN_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start_i) begin
      sh_q   <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      ovf_q  <= (bin_i > BCD_MAX);
    end else if (busy_q) begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == LAST_IT) busy_q <= 1'b0;
    end
  end

  // High during the cycle whose closing edge performs the final iteration.
  assign done_o = busy_q && (cnt_q == LAST_IT);
  assign ovf_o  = ovf_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_disp_ctrl.sv
// Arbitrates a persistent (A) and a timed overlay (B) requester, converts the
// winning value to decimal and registers six active-low 7-segment patterns.
module seg_disp_ctrl
  import seg_disp_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned OVERLAY_MS = 2000,
  parameter bit          LZ_BLANK   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [19:0] data_a,
  input  logic [5:0]  dp_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [19:0] data_b,
  input  logic [5:0]  dp_b,
  output logic        ack_b,
  output logic        busy,
  output logic        overlay,
  output logic [7:0]  seg_data_0,
  output logic [7:0]  seg_data_1,
  output logic [7:0]  seg_data_2,
  output logic [7:0]  seg_data_3,
  output logic [7:0]  seg_data_4,
  output logic [7:0]  seg_data_5
);

  localparam int unsigned OVERLAY_CYC = CLK_FREQ / 1000 * OVERLAY_MS;
  localparam logic [31:0] TIMER_LAST  = 32'(OVERLAY_CYC - 1);

  state_e           state_q;
  logic             conv_b_q;
  logic [5:0]       dp_conv_q;
  logic [BIN_W-1:0] a_last_q;
  logic [5:0]       dp_last_q;
  logic             a_valid_q, restore_pend_q, overlay_q;
  logic [31:0]      timer_q;
  logic             ack_a_q, ack_b_q;
  logic [7:0]       seg_q [NDIG];
  logic [7:0]       seg_d [NDIG];

  logic             take_b, take_a, start;
  logic [BIN_W-1:0] conv_bin;
  logic             conv_done, conv_ovf;
  logic [BCD_W-1:0] conv_bcd;
  logic             lead;
  logic [3:0]       dig;

  // A request still high in the cycle of its own ack is the requester dropping it.
  assign take_b   = (state_q == ST_IDLE) && req_b && !ack_b_q;
  assign take_a   = (state_q == ST_IDLE) && !take_b && !restore_pend_q && req_a && !ack_a_q;
  assign start    = take_b || ((state_q == ST_IDLE) && restore_pend_q) || (take_a && !overlay_q);
  assign conv_bin = take_b ? data_b : (restore_pend_q ? a_last_q : data_a);

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (conv_bin),
    .done_o  (conv_done),
    .ovf_o   (conv_ovf),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    seg_d = '{default: SEG_BLANK};
    dig   = '0;
    lead  = LZ_BLANK;
    for (int unsigned i = 0; i < NDIG; i++) begin
      dig = conv_bcd[BCD_W-1-4*i -: 4];
      if (conv_ovf)                                   seg_d[i] = SEG_DASH;
      else if (lead && dig == 4'd0 && i != NDIG - 1)  seg_d[i] = SEG_BLANK;
      else                                            seg_d[i] = digit_to_seg(dig);
      if (dig != 4'd0) lead = 1'b0;
      if (dp_conv_q[i]) seg_d[i][7] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      conv_b_q       <= 1'b0;
      dp_conv_q      <= '0;
      a_last_q       <= '0;
      dp_last_q      <= '0;
      a_valid_q      <= 1'b0;
      restore_pend_q <= 1'b0;
      overlay_q      <= 1'b0;
      timer_q        <= '0;
      ack_a_q        <= 1'b0;
      ack_b_q        <= 1'b0;
      seg_q          <= '{default: SEG_BLANK};
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;

      // Timer is frozen while a new B converts so it cannot expire under it.
      if (take_b) begin
        timer_q <= '0;
      end else if (overlay_q && state_q == ST_IDLE) begin
        if (timer_q == TIMER_LAST) begin
          overlay_q      <= 1'b0;
          restore_pend_q <= a_valid_q || take_a;
          if (!(a_valid_q || take_a)) seg_q <= '{default: SEG_BLANK};
        end else begin
          timer_q <= timer_q + 32'd1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (take_b) begin
            ack_b_q   <= 1'b1;
            dp_conv_q <= dp_b;
            conv_b_q  <= 1'b1;
            state_q   <= ST_CONV;
          end else if (restore_pend_q) begin
            restore_pend_q <= 1'b0;
            dp_conv_q      <= dp_last_q;
            conv_b_q       <= 1'b0;
            state_q        <= ST_CONV;
          end else if (take_a) begin
            ack_a_q   <= 1'b1;
            a_last_q  <= data_a;
            dp_last_q <= dp_a;
            a_valid_q <= 1'b1;
            if (!overlay_q) begin
              dp_conv_q <= dp_a;
              conv_b_q  <= 1'b0;
              state_q   <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          if (conv_done) state_q <= ST_ENC;
        end
        ST_ENC: begin
          seg_q   <= seg_d;
          state_q <= ST_IDLE;
          if (conv_b_q) begin
            overlay_q <= 1'b1;
            timer_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;
  assign busy       = (state_q != ST_IDLE);
  assign overlay    = overlay_q;
  assign seg_data_0 = seg_q[0];
  assign seg_data_1 = seg_q[1];
  assign seg_data_2 = seg_q[2];
  assign seg_data_3 = seg_q[3];
  assign seg_data_4 = seg_q[4];
  assign seg_data_5 = seg_q[5];

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl: arbitration, conversion latency, blanking,
// overflow dashes, overlay hold/restore and mid-conversion reset.
module tb_seg_disp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic [19:0] data_a, data_b;
  logic [5:0]  dp_a, dp_b;
  logic        ack_a, ack_b, busy, overlay;
  logic [7:0]  s0, s1, s2, s3, s4, s5;
  logic [47:0] segs;

  logic        req_a2;
  logic [19:0] data_a2;
  logic        ack_a2, ack_b2, busy2, overlay2;
  logic [7:0]  t0, t1, t2, t3, t4, t5;
  logic [47:0] segs2;

  int checks = 0;
  int errors = 0;

  assign segs  = {s0, s1, s2, s3, s4, s5};
  assign segs2 = {t0, t1, t2, t3, t4, t5};

  always #5 clk = ~clk;

  seg_disp_ctrl #(.CLK_FREQ(10000), .OVERLAY_MS(2), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .dp_a(dp_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .dp_b(dp_b), .ack_b(ack_b),
    .busy(busy), .overlay(overlay),
    .seg_data_0(s0), .seg_data_1(s1), .seg_data_2(s2),
    .seg_data_3(s3), .seg_data_4(s4), .seg_data_5(s5)
  );

  seg_disp_ctrl #(.CLK_FREQ(10000), .OVERLAY_MS(2), .LZ_BLANK(1'b0)) dut_nolz (
    .clk(clk), .rst(rst),
    .req_a(req_a2), .data_a(data_a2), .dp_a(6'b000000), .ack_a(ack_a2),
    .req_b(1'b0), .data_b(20'd0), .dp_b(6'b000000), .ack_b(ack_b2),
    .busy(busy2), .overlay(overlay2),
    .seg_data_0(t0), .seg_data_1(t1), .seg_data_2(t2),
    .seg_data_3(t3), .seg_data_4(t4), .seg_data_5(t5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [19:0] v, input logic [5:0] d, output bit got);
    req_a = 1'b1; data_a = v; dp_a = d; got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      tick();
      if (ack_a === 1'b1) got = 1'b1;
    end
    req_a = 1'b0;
  endtask

  task automatic drive_b(input logic [19:0] v, input logic [5:0] d, output bit got);
    req_b = 1'b1; data_b = v; dp_b = d; got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      tick();
      if (ack_b === 1'b1) got = 1'b1;
    end
    req_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_a = 0; req_b = 0; data_a = 0; data_b = 0; dp_a = 0; dp_b = 0;
    req_a2 = 0; data_a2 = 0;
    tick();
    checks++;
    if (segs !== 48'hffffffffffff) begin
      errors++; $display("FAIL reset_segs got %h want ffffffffffff", segs);
    end
    checks++;
    if ({ack_a, ack_b, busy, overlay} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {ack_a, ack_b, busy, overlay});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit got;
    drive_a(20'd123456, 6'b000000, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL basic_ack got %b want 1", got); end
    tick();
    checks++;
    if ({ack_a, busy} !== 2'b01) begin
      errors++; $display("FAIL basic_ack_pulse got ack=%b busy=%b want ack=0 busy=1", ack_a, busy);
    end
    repeat (19) tick();
    checks++;
    if (segs !== 48'hffffffffffff || busy !== 1'b1) begin
      errors++; $display("FAIL basic_latency_e20 got %h busy=%b want ffffffffffff busy=1", segs, busy);
    end
    tick();
    checks++;
    if (segs !== 48'hf9a4b0999282) begin
      errors++; $display("FAIL basic_segs got %h want f9a4b0999282", segs);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_lz();
    bit got;
    drive_a(20'd42, 6'b000000, got);
    repeat (21) tick();
    checks++;
    if (segs !== 48'hffffffff99a4) begin
      errors++; $display("FAIL lz_42 got %h want ffffffff99a4", segs);
    end
    drive_a(20'd0, 6'b000000, got);
    repeat (21) tick();
    checks++;
    if (segs !== 48'hffffffffffc0) begin
      errors++; $display("FAIL lz_0 got %h want ffffffffffc0", segs);
    end
    req_a2 = 1'b1; data_a2 = 20'd42; got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      tick();
      if (ack_a2 === 1'b1) got = 1'b1;
    end
    req_a2 = 1'b0;
    repeat (21) tick();
    checks++;
    if (segs2 !== 48'hc0c0c0c099a4) begin
      errors++; $display("FAIL nolz_42 got %h want c0c0c0c099a4", segs2);
    end
  endtask

  task automatic test_overflow();
    bit got;
    drive_a(20'd1000000, 6'b000100, got);
    repeat (21) tick();
    checks++;
    if (segs !== 48'hbfbf3fbfbfbf) begin
      errors++; $display("FAIL ovf_1000000 got %h want bfbf3fbfbfbf", segs);
    end
    drive_a(20'd999999, 6'b100001, got);
    repeat (21) tick();
    checks++;
    if (segs !== 48'h109090909010) begin
      errors++; $display("FAIL max_999999_dp got %h want 109090909010", segs);
    end
  endtask

  task automatic test_overlay();
    bit got;
    drive_a(20'd5, 6'b000000, got);
    repeat (21) tick();
    checks++;
    if (segs !== 48'hffffffffff92) begin
      errors++; $display("FAIL ovl_a5 got %h want ffffffffff92", segs);
    end
    drive_b(20'd77, 6'b000000, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL ovl_ack_b got %b want 1", got); end
    repeat (20) tick();
    checks++;
    if (overlay !== 1'b0) begin errors++; $display("FAIL ovl_early got %b want 0", overlay); end
    tick();
    checks++;
    if (segs !== 48'hfffffffff8f8 || overlay !== 1'b1) begin
      errors++; $display("FAIL ovl_b77 got %h ovl=%b want fffffffff8f8 ovl=1", segs, overlay);
    end
    drive_a(20'd9, 6'b000000, got);
    checks++;
    if (got !== 1'b1 || busy !== 1'b0 || segs !== 48'hfffffffff8f8) begin
      errors++; $display("FAIL ovl_a_during got ack=%b busy=%b segs=%h want 1 0 fffffffff8f8", got, busy, segs);
    end
    repeat (18) tick();
    checks++;
    if (overlay !== 1'b1) begin errors++; $display("FAIL ovl_hold got %b want 1", overlay); end
    tick();
    checks++;
    if (overlay !== 1'b0) begin errors++; $display("FAIL ovl_expire got %b want 0", overlay); end
    tick();
    checks++;
    if ({busy, ack_a, ack_b} !== 3'b100) begin
      errors++; $display("FAIL ovl_restore_start got busy/ack_a/ack_b=%b want 100", {busy, ack_a, ack_b});
    end
    repeat (20) tick();
    checks++;
    if (segs !== 48'hfffffffff8f8) begin
      errors++; $display("FAIL ovl_restore_early got %h want fffffffff8f8", segs);
    end
    tick();
    checks++;
    if (segs !== 48'hffffffffff90) begin
      errors++; $display("FAIL ovl_restore got %h want ffffffffff90", segs);
    end
  endtask

  task automatic test_back_to_back();
    bit a_seen;
    req_a = 1'b1; data_a = 20'd321; dp_a = 6'b000000;
    req_b = 1'b1; data_b = 20'd55;  dp_b = 6'b000000;
    tick();
    checks++;
    if ({ack_b, ack_a} !== 2'b10) begin
      errors++; $display("FAIL b2b_first got ack_b/ack_a=%b want 10", {ack_b, ack_a});
    end
    req_b = 1'b0;
    a_seen = 1'b0;
    repeat (21) begin
      tick();
      if (ack_a === 1'b1) a_seen = 1'b1;
    end
    checks++;
    if (a_seen !== 1'b0 || segs !== 48'hffffffff9292 || overlay !== 1'b1) begin
      errors++; $display("FAIL b2b_b_done got early_ack_a=%b segs=%h ovl=%b want 0 ffffffff9292 1", a_seen, segs, overlay);
    end
    tick();
    checks++;
    if (ack_a !== 1'b1) begin errors++; $display("FAIL b2b_ack_a got %b want 1", ack_a); end
    req_a = 1'b0;
    tick();
    checks++;
    if ({ack_a, ack_b, busy} !== 3'b000) begin
      errors++; $display("FAIL b2b_no_extra got ack_a/ack_b/busy=%b want 000", {ack_a, ack_b, busy});
    end
    repeat (40) tick();
    checks++;
    if (segs !== 48'hffffffb0a4f9) begin
      errors++; $display("FAIL b2b_restore got %h want ffffffb0a4f9", segs);
    end
  endtask

  task automatic test_rst_mid();
    bit got;
    req_a = 1'b1; data_a = 20'd123; dp_a = 6'b000000; got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      tick();
      if (ack_a === 1'b1) got = 1'b1;
    end
    repeat (5) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (segs !== 48'hffffffffffff || {ack_a, ack_b, busy, overlay} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid got segs=%h flags=%b want ffffffffffff 0000", segs, {ack_a, ack_b, busy, overlay});
    end
    tick();
    rst = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      tick();
      if (ack_a === 1'b1) got = 1'b1;
    end
    req_a = 1'b0;
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL rst_reack got %b want 1", got); end
    repeat (21) tick();
    checks++;
    if (segs !== 48'hfffffff9a4b0) begin
      errors++; $display("FAIL rst_after got %h want fffffff9a4b0", segs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_overflow();
    test_overlay();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
